// File: rtl/bus_pkg.sv
// Shared widths and FSM encoding for the memory bus arbiter.
package bus_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 3;  // holds MEM_LATENCY up to 7
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared bus.
// The slave modport is the arbiter; the master modport is its environment.
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ-1:0]        reqWrite;
  logic [NUM_REQ*DATA_W-1:0] reqWdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         memAddr;
  logic                      memWrite;
  logic [DATA_W-1:0]         memWdata;
  logic [DATA_W-1:0]         memRdata;

  modport slave (
    input  req, lock, reqAddr, reqWrite, reqWdata, memRdata,
    output gnt, ack, rdata, busy, memAddr, memWrite, memWdata
  );

  modport master (
    output req, lock, reqAddr, reqWrite, reqWdata, memRdata,
    input  gnt, ack, rdata, busy, memAddr, memWrite, memWdata
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first request above lastGrant, wrapping to
// the lowest-numbered request when nothing above it is pending.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] upper;
  logic               found;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    upper  = '0;
    pick_o = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      upper[k] = req_i[k] && (k > int'(last_grant_i));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && upper[k]) begin
        pick_o[k] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[k]) begin
        pick_o[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 12-bit address / 8-bit data memory bus
// between NUM_REQ masters, one transaction per grant with optional lock.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MEM_LATENCY = 1
) (
  input logic          clock,
  input logic          resetN,
  bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("bus_arbiter: NUM_REQ must be 2..4");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("bus_arbiter: MEM_LATENCY must be 1..7");
  end

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    owner_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_write_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  logic                lock_hold;
  logic                start_d;
  logic [IDX_W-1:0]    lat_idx_d;
  logic [NUM_REQ-1:0]  lat_gnt_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g]  = bus.reqAddr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.reqWdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i        (bus.req),
    .last_grant_i (last_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = IDX_W'(k);
    end
  end

  // A lock only counts for the current owner, and only while it still requests.
  assign lock_hold = bus.lock[owner_q] && bus.req[owner_q];

  always_comb begin
    start_d   = 1'b0;
    lat_idx_d = pick_idx;
    lat_gnt_d = pick;
    if (state_q == IDLE) begin
      start_d = pick_valid;
    end else if (state_q == DONE) begin
      start_d   = lock_hold;
      lat_idx_d = owner_q;
      lat_gnt_d = gnt_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: ;
        ACCESS: begin
          if (cnt_q == CNT_W'(1)) begin
            if (!mem_write_q) rdata_q <= bus.memRdata;
            ack_q       <= gnt_q;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          last_q <= owner_q;
          if (!start_d) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q       <= '0;
          mem_write_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase

      // New grant from IDLE, or a locked owner re-latching from DONE.
      if (start_d) begin
        owner_q     <= lat_idx_d;
        gnt_q       <= lat_gnt_d;
        mem_addr_q  <= addr_a[lat_idx_d];
        mem_write_q <= bus.reqWrite[lat_idx_d];
        mem_wdata_q <= wdata_a[lat_idx_d];
        cnt_q       <= CNT_W'(MEM_LATENCY);
        state_q     <= ACCESS;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWrite = mem_write_q;
  assign bus.memWdata = mem_wdata_q;

  a_gnt_onehot : assert property (@(posedge clock) disable iff (!resetN)
    $onehot0(gnt_q));
  a_ack_owner : assert property (@(posedge clock) disable iff (!resetN)
    (ack_q & ~gnt_q) == '0);
  a_write_in_access : assert property (@(posedge clock) disable iff (!resetN)
    mem_write_q |-> state_q == ACCESS);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: latency-1 arbiter for read/write/contention/lock/reset,
// plus a latency-3 instance for the capture-timing sweep.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_REQ(2)) bus1 ();
  bus_arbiter_if #(.NUM_REQ(2)) bus3 ();

  bus_arbiter #(.NUM_REQ(2), .MEM_LATENCY(1)) dut1 (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus1)
  );

  bus_arbiter #(.NUM_REQ(2), .MEM_LATENCY(3)) dut3 (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus3)
  );

  // Memory model for the latency-1 instance: 0x3C at 0x123, else addr[7:0]^0x5A.
  assign bus1.memRdata = (bus1.memAddr == 12'h123) ? 8'h3C : (bus1.memAddr[7:0] ^ 8'h5A);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req1(input int idx, input logic [11:0] addr, input logic wr, input logic [7:0] wd);
    bus1.reqAddr[idx*12 +: 12] = addr;
    bus1.reqWrite[idx]         = wr;
    bus1.reqWdata[idx*8 +: 8]  = wd;
  endtask

  initial begin
    resetN        = 1'b0;
    bus1.req      = '0;
    bus1.lock     = '0;
    bus1.reqAddr  = '0;
    bus1.reqWrite = '0;
    bus1.reqWdata = '0;
    bus3.req      = '0;
    bus3.lock     = '0;
    bus3.reqAddr  = '0;
    bus3.reqWrite = '0;
    bus3.reqWdata = '0;
    bus3.memRdata = '0;
    #1;
    step();
    step();

    // Reset state
    check("rst_gnt",    32'(bus1.gnt), 32'h0);
    check("rst_ack",    32'(bus1.ack), 32'h0);
    check("rst_busy",   32'(bus1.busy), 32'h0);
    check("rst_mwrite", 32'(bus1.memWrite), 32'h0);
    check("rst_maddr",  32'(bus1.memAddr), 32'h0);
    check("rst_mwdata", 32'(bus1.memWdata), 32'h0);
    check("rst_rdata",  32'(bus1.rdata), 32'h0);
    resetN = 1'b1;
    step();

    // Single read by requester 0; req dropped during ACCESS still completes
    set_req1(0, 12'h123, 1'b0, 8'h00);
    bus1.req = 2'b01;
    step();
    check("rd_gnt",    32'(bus1.gnt), 32'h1);
    check("rd_maddr",  32'(bus1.memAddr), 32'h123);
    check("rd_mwrite", 32'(bus1.memWrite), 32'h0);
    check("rd_busy",   32'(bus1.busy), 32'h1);
    check("rd_ack_early", 32'(bus1.ack), 32'h0);
    bus1.req = 2'b00;
    step();
    check("rd_ack",    32'(bus1.ack), 32'h1);
    check("rd_rdata",  32'(bus1.rdata), 32'h3C);
    check("rd_gnt_done", 32'(bus1.gnt), 32'h1);
    check("rd_mwrite_done", 32'(bus1.memWrite), 32'h0);
    step();
    check("rd_ack_clear", 32'(bus1.ack), 32'h0);
    check("rd_idle_gnt",  32'(bus1.gnt), 32'h0);
    check("rd_idle_busy", 32'(bus1.busy), 32'h0);
    check("rd_rdata_held", 32'(bus1.rdata), 32'h3C);

    // Single write by requester 1
    set_req1(1, 12'h055, 1'b1, 8'hA7);
    bus1.req = 2'b10;
    step();
    check("wr_gnt",    32'(bus1.gnt), 32'h2);
    check("wr_mwrite", 32'(bus1.memWrite), 32'h1);
    check("wr_maddr",  32'(bus1.memAddr), 32'h055);
    check("wr_mwdata", 32'(bus1.memWdata), 32'hA7);
    step();
    check("wr_ack",    32'(bus1.ack), 32'h2);
    check("wr_mwrite_off", 32'(bus1.memWrite), 32'h0);
    check("wr_rdata_kept", 32'(bus1.rdata), 32'h3C);
    bus1.req = 2'b00;
    step();
    check("wr_idle_gnt", 32'(bus1.gnt), 32'h0);

    // Contention: both request, winner drops on ack and re-raises after
    set_req1(0, 12'h010, 1'b0, 8'h00);
    set_req1(1, 12'h020, 1'b0, 8'h00);
    bus1.req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] exp_oh;
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      step();
      check($sformatf("cont%0d_gnt", t), 32'(bus1.gnt), 32'(exp_oh));
      check($sformatf("cont%0d_noack", t), 32'(bus1.ack), 32'h0);
      step();
      check($sformatf("cont%0d_ack", t), 32'(bus1.ack), 32'(exp_oh));
      bus1.req = bus1.req & ~exp_oh;
      step();
      check($sformatf("cont%0d_ack_pulse", t), 32'(bus1.ack), 32'h0);
      check($sformatf("cont%0d_release", t), 32'(bus1.gnt), 32'h0);
      bus1.req = 2'b11;
    end
    bus1.req = 2'b00;
    step();

    // Lock burst: requester 1 does three locked reads while requester 0 waits
    set_req1(1, 12'h200, 1'b0, 8'h00);
    bus1.req  = 2'b10;
    bus1.lock = 2'b10;
    for (int b = 0; b < 3; b++) begin
      logic [7:0] exp_rd;
      exp_rd = (8'(b) | 8'h00) ^ 8'h5A;
      step();
      bus1.req = 2'b11;
      check($sformatf("lock%0d_gnt", b), 32'(bus1.gnt), 32'h2);
      check($sformatf("lock%0d_maddr", b), 32'(bus1.memAddr), 32'(12'h200 + 12'(b)));
      check($sformatf("lock%0d_noack", b), 32'(bus1.ack), 32'h0);
      step();
      check($sformatf("lock%0d_ack", b), 32'(bus1.ack), 32'h2);
      check($sformatf("lock%0d_rdata", b), 32'(bus1.rdata), 32'(exp_rd));
      if (b < 2) begin
        set_req1(1, 12'h200 + 12'(b + 1), 1'b0, 8'h00);
      end else begin
        bus1.lock = 2'b00;
        bus1.req  = 2'b01;
      end
    end
    step();
    check("lock_release_gnt", 32'(bus1.gnt), 32'h0);
    step();
    check("lock_then_req0", 32'(bus1.gnt), 32'h1);
    bus1.req = 2'b00;
    step();
    check("lock_req0_ack", 32'(bus1.ack), 32'h1);
    step();

    // Reset mid-write
    set_req1(0, 12'h0AA, 1'b1, 8'h99);
    bus1.req = 2'b01;
    step();
    check("rstw_mwrite_on", 32'(bus1.memWrite), 32'h1);
    resetN = 1'b0;
    set_req1(0, 12'h0AB, 1'b0, 8'h00);
    set_req1(1, 12'h0AC, 1'b0, 8'h00);
    bus1.req = 2'b11;
    step();
    check("rstw_mwrite", 32'(bus1.memWrite), 32'h0);
    check("rstw_gnt",    32'(bus1.gnt), 32'h0);
    check("rstw_busy",   32'(bus1.busy), 32'h0);
    check("rstw_ack",    32'(bus1.ack), 32'h0);
    resetN = 1'b1;
    step();
    check("rstw_first_gnt", 32'(bus1.gnt), 32'h1);
    check("rstw_first_addr", 32'(bus1.memAddr), 32'h0AB);
    bus1.req = 2'b00;
    step();
    check("rstw_no_stale_ack", 32'(bus1.ack), 32'h1);
    step();

    // Latency sweep on the MEM_LATENCY=3 instance
    bus3.reqAddr[11:0] = 12'h3F0;
    bus3.reqWrite[0]   = 1'b0;
    bus3.req           = 2'b01;
    step();
    check("lat3_maddr0", 32'(bus3.memAddr), 32'h3F0);
    check("lat3_noack0", 32'(bus3.ack), 32'h0);
    bus3.memRdata = 8'h11;
    step();
    check("lat3_maddr1", 32'(bus3.memAddr), 32'h3F0);
    check("lat3_noack1", 32'(bus3.ack), 32'h0);
    bus3.memRdata = 8'h22;
    step();
    check("lat3_maddr2", 32'(bus3.memAddr), 32'h3F0);
    check("lat3_noack2", 32'(bus3.ack), 32'h0);
    bus3.memRdata = 8'h33;
    bus3.req      = 2'b00;
    step();
    check("lat3_ack",   32'(bus3.ack), 32'h1);
    check("lat3_rdata", 32'(bus3.rdata), 32'h33);
    bus3.memRdata = 8'h44;
    step();
    check("lat3_ack_clear", 32'(bus3.ack), 32'h0);
    check("lat3_rdata_held", 32'(bus3.rdata), 32'h33);
    check("lat3_idle", 32'(bus3.busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
